power_spec_accum: RTL and testbench

//  Consumer of the power-spectrum stream from the FFT/|X|^2 stage (Power_Spec[49:0] + data_valid,
//  512 contiguous bins per frame, upper half of a 1024-pt FFT). Accumulates N consecutive frames
//  bin-by-bin into a 512-entry block RAM for multi-pulse averaging, then streams the 512 sums out

---
 rtl/power_spec_accum.sv | 222 ++++++++++++++++++++++
 tb/tb_power_spec_accum.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_spec_accum.sv
// power_spec_accum: accumulates N frames of 512 power-spectrum bins into a
// block RAM (read-modify-write pipeline) and streams the bin sums out.
// Ports: clk/rst (sync, active-high); acc_start/acc_num start a run;
//   Power_Spec/data_valid carry the bin stream; out_* is a valid/ready result
//   stream (out_addr = bin index, out_last on the final bin); acc_busy/acc_done
//   report run phase; frame_cnt/frame_err report frames seen and short frames.
module power_spec_accum #(
  parameter int NBINS = 512,
  parameter int IN_W  = 50,
  parameter int ACC_W = 66
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_start,
  input  logic [15:0]              acc_num,
  input  logic [IN_W-1:0]          Power_Spec,
  input  logic                     data_valid,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_data,
  output logic [$clog2(NBINS)-1:0] out_addr,
  output logic                     out_last,
  output logic                     acc_busy,
  output logic                     acc_done,
  output logic [15:0]              frame_cnt,
  output logic                     frame_err
);

  localparam int BW = $clog2(NBINS);
  localparam logic [BW-1:0] LAST_BIN = BW'(NBINS - 1);
  localparam logic [BW:0]   RD_END   = (BW + 1)'(NBINS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_ACCUM   = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_READOUT = 3'd4;

  logic [2:0]       state;
  logic [15:0]      target;
  logic             dv_q;
  logic             in_frame;
  logic [BW-1:0]    bin_cnt;
  logic             flush_cnt;

  // Frame delimiting
  logic accepting;
  logic rise;
  logic take;
  logic end_full;
  logic end_part;
  logic frame_end;
  logic last_frame;

  assign accepting = (state == ST_ARM) || (state == ST_ACCUM);
  assign rise      = data_valid & ~dv_q;
  // A strobe is only taken inside a frame that began with a rising edge
  // while we were armed/accumulating; this is what skips a frame already
  // in progress when the run was started.
  assign take      = accepting & data_valid & (in_frame | rise);
  assign end_full  = take & (bin_cnt == LAST_BIN);
  assign end_part  = accepting & in_frame & ~data_valid;
  assign frame_end = end_full | end_part;
  assign last_frame = ({1'b0, frame_cnt} + 17'd1) >= {1'b0, target};

  // Readout handshake
  logic          advance;
  logic          rd_fetch;
  logic [BW:0]   rd_ptr;

  assign advance  = (state == ST_READOUT) && (!out_valid || out_ready);
  assign rd_fetch = advance && (rd_ptr != RD_END);

  // Control FSM and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      target    <= 16'd0;
      dv_q      <= 1'b0;
      in_frame  <= 1'b0;
      bin_cnt   <= '0;
      frame_cnt <= 16'd0;
      frame_err <= 1'b0;
      flush_cnt <= 1'b0;
    end else begin
      dv_q <= data_valid;

      case (state)
        ST_IDLE: begin
          if (acc_start) begin
            target    <= (acc_num == 16'd0) ? 16'd1 : acc_num;
            frame_cnt <= 16'd0;
            frame_err <= 1'b0;
            bin_cnt   <= '0;
            in_frame  <= 1'b0;
            state     <= ST_ARM;
          end
        end
        ST_ARM, ST_ACCUM: begin
          if (frame_end && last_frame) begin
            state     <= ST_FLUSH;
            flush_cnt <= 1'b0;
          end else if (state == ST_ARM && take) begin
            state <= ST_ACCUM;
          end
        end
        ST_FLUSH: begin
          // Two cycles let the last read-modify-write reach the RAM.
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= ST_READOUT;
        end
        ST_READOUT: begin
          if (out_valid && out_ready && out_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // These only fire in ARM/ACCUM, so they never collide with IDLE.
      if (take) begin
        bin_cnt  <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + 1'b1;
        in_frame <= (bin_cnt != LAST_BIN);
      end
      if (end_part) begin
        bin_cnt   <= '0;
        in_frame  <= 1'b0;
        frame_err <= 1'b1;
      end
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Accumulate pipeline: read at t, add at t+1, write at t+2
  logic             s1_vld;
  logic [BW-1:0]    s1_addr;
  logic [IN_W-1:0]  s1_dat;
  logic             s1_first;
  logic             byp_q;
  logic [ACC_W-1:0] byp_dat;
  logic             s2_vld;
  logic [BW-1:0]    s2_addr;
  logic [ACC_W-1:0] s2_sum;
  logic [ACC_W-1:0] ram_q;
  logic [ACC_W-1:0] prev;
  logic [ACC_W-1:0] sum;

  // The first frame of a run overwrites, so the RAM never needs clearing.
  // A read that collides with the write in the same cycle (only possible
  // with very short frames) takes the value being written.
  assign prev = s1_first ? '0 : (byp_q ? byp_dat : ram_q);
  assign sum  = prev + {{(ACC_W - IN_W){1'b0}}, s1_dat};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_addr  <= '0;
      s1_dat   <= '0;
      s1_first <= 1'b0;
      byp_q    <= 1'b0;
      byp_dat  <= '0;
      s2_vld   <= 1'b0;
      s2_addr  <= '0;
      s2_sum   <= '0;
    end else begin
      s1_vld   <= take;
      s1_addr  <= bin_cnt;
      s1_dat   <= Power_Spec;
      // Captured with the strobe: frame_cnt bumps on the last bin itself.
      s1_first <= (frame_cnt == 16'd0);
      byp_q    <= take && s2_vld && (s2_addr == bin_cnt);
      byp_dat  <= s2_sum;
      s2_vld   <= s1_vld;
      s2_addr  <= s1_addr;
      s2_sum   <= sum;
    end
  end

  // Bin RAM: one write port, one registered read port shared between the
  // accumulate path and the readout prefetch (never active together).
  logic [ACC_W-1:0] ram [NBINS];
  logic             rd_en;
  logic [BW-1:0]    rd_addr;

  assign rd_en   = take | rd_fetch;
  assign rd_addr = (state == ST_READOUT) ? rd_ptr[BW-1:0] : bin_cnt;

  always_ff @(posedge clk) begin
    if (s2_vld) ram[s2_addr] <= s2_sum;
  end

  // Read register doubles as the output data register: it only loads when
  // the current beat is accepted (or absent), so data holds under stall.
  always_ff @(posedge clk) begin
    if (rst) ram_q <= '0;
    else if (rd_en) ram_q <= ram[rd_addr];
  end

  // Readout sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
    end else if (state != ST_READOUT) begin
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      if (rd_fetch) begin
        out_valid <= 1'b1;
        out_addr  <= rd_ptr[BW-1:0];
        rd_ptr    <= rd_ptr + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_data = out_valid ? ram_q : '0;
  assign out_last = out_valid && (out_addr == LAST_BIN);
  assign acc_busy = (state == ST_ARM) || (state == ST_ACCUM) || (state == ST_FLUSH);
  assign acc_done = (state == ST_READOUT);

endmodule

// File: tb/tb_power_spec_accum.sv
// Testbench for power_spec_accum: drives frames, keeps a reference RAM
// image, and scoreboards the readout stream beat by beat.
module tb_power_spec_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_start;
  logic [15:0] acc_num;
  logic [49:0] Power_Spec;
  logic        data_valid;
  logic        out_ready;
  logic        out_valid;
  logic [65:0] out_data;
  logic [8:0]  out_addr;
  logic        out_last;
  logic        acc_busy;
  logic        acc_done;
  logic [15:0] frame_cnt;
  logic        frame_err;

  power_spec_accum dut (
    .clk(clk), .rst(rst), .acc_start(acc_start), .acc_num(acc_num),
    .Power_Spec(Power_Spec), .data_valid(data_valid), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .acc_busy(acc_busy), .acc_done(acc_done),
    .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [65:0] d;
    logic [8:0]  a;
    logic        l;
  } beat_t;

  int          total = 0;
  int          bad = 0;
  int          run_frames = 0;
  logic [65:0] mod_ram [512];
  beat_t       exp_q [$];

  task automatic start_run(input logic [15:0] n);
    acc_num   = n;
    acc_start = 1'b1;
    @(negedge clk);
    acc_start  = 1'b0;
    run_frames = 0;
  endtask

  // mode 0: ramp (bin index), 1: constant base, 2: random
  task automatic drive_frame(input int n, input int mode, input logic [49:0] base,
                             input bit counted, input int start_at,
                             input logic [15:0] start_num);
    logic [63:0] r;
    logic [49:0] v;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       v = 50'(i);
        1:       v = base;
        default: begin r = {$urandom, $urandom}; v = r[49:0]; end
      endcase
      data_valid = 1'b1;
      Power_Spec = v;
      acc_start  = (i == start_at);
      if (i == start_at) acc_num = start_num;
      if (counted)
        mod_ram[i] = (run_frames == 0) ? {16'd0, v} : mod_ram[i] + {16'd0, v};
      @(negedge clk);
    end
    data_valid = 1'b0;
    acc_start  = 1'b0;
    Power_Spec = '0;
    if (counted) run_frames++;
    @(negedge clk);
  endtask

  task automatic push_expected();
    for (int i = 0; i < 512; i++) exp_q.push_back('{d: mod_ram[i], a: 9'(i), l: (i == 511)});
  endtask

  task automatic readout(input bit rnd, input string name);
    int          beats = 0;
    int          cyc = 0;
    bit          stall_prev = 0;
    bit          first = 1;
    logic [65:0] held_d = '0;
    logic [8:0]  held_a = '0;
    beat_t       e;
    push_expected();
    while (beats < 512 && cyc < 4000) begin
      if (stall_prev) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_addr !== held_a) begin
          bad++;
          $display("FAIL %s stall_hold: got v=%b a=%0d d=%0h want v=1 a=%0d d=%0h",
                   name, out_valid, out_addr, out_data, held_a, held_d);
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && first) begin
        first = 0;
        total++;
        if (acc_done !== 1'b1 || acc_busy !== 1'b0) begin
          bad++;
          $display("FAIL %s done_flag: got done=%b busy=%b want done=1 busy=0",
                   name, acc_done, acc_busy);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        e = exp_q.pop_front();
        total++;
        if (out_data !== e.d || out_addr !== e.a || out_last !== e.l) begin
          bad++;
          $display("FAIL %s beat%0d: got a=%0d d=%0h last=%b want a=%0d d=%0h last=%b",
                   name, beats, out_addr, out_data, out_last, e.a, e.d, e.l);
        end
        beats++;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      held_d = out_data;
      held_a = out_addr;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (beats != 512) begin
      bad++;
      $display("FAIL %s beat_count: got %0d want 512 (timeout)", name, beats);
    end
    exp_q.delete();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || acc_done !== 1'b0 || acc_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s back_to_idle: got v=%b done=%b busy=%b want 0 0 0",
               name, out_valid, acc_done, acc_busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || out_last !== 1'b0 ||
        acc_busy !== 1'b0 || acc_done !== 1'b0 || frame_cnt !== 16'd0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s: got v=%b d=%0h a=%0d l=%b busy=%b done=%b fc=%0d err=%b want all 0",
               name, out_valid, out_data, out_addr, out_last, acc_busy, acc_done,
               frame_cnt, frame_err);
    end
  endtask

  task automatic check_stats(input string name, input logic [15:0] fc, input logic err);
    total++;
    if (frame_cnt !== fc || frame_err !== err) begin
      bad++;
      $display("FAIL %s stats: got fc=%0d err=%b want fc=%0d err=%b",
               name, frame_cnt, frame_err, fc, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; acc_start = 1'b0; acc_num = '0; Power_Spec = '0;
    data_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_single();
    start_run(16'd1);
    drive_frame(512, 0, '0, 1, -1, '0);
    readout(0, "single");
    check_stats("single", 16'd1, 1'b0);
  endtask

  task automatic test_max();
    start_run(16'd4);
    for (int f = 0; f < 4; f++) drive_frame(512, 1, {1'b0, {49{1'b1}}}, 1, -1, '0);
    readout(0, "max");
    check_stats("max", 16'd4, 1'b0);
  endtask

  task automatic test_midframe();
    // Start lands 100 bins into a frame: that frame must be skipped.
    drive_frame(512, 1, 50'd999, 0, 100, 16'd3);
    run_frames = 0;
    total++;
    if (acc_busy !== 1'b1 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midframe skip: got busy=%b fc=%0d want busy=1 fc=0", acc_busy, frame_cnt);
    end
    drive_frame(512, 2, '0, 1, -1, '0);
    // A start pulse while accumulating must be ignored.
    drive_frame(512, 2, '0, 1, 50, 16'd1);
    drive_frame(512, 2, '0, 1, -1, '0);
    readout(0, "midframe");
    check_stats("midframe", 16'd3, 1'b0);
  endtask

  task automatic test_partial();
    start_run(16'd2);
    drive_frame(512, 2, '0, 1, -1, '0);
    drive_frame(300, 1, 50'd7, 1, -1, '0);
    check_stats("partial_pre", 16'd2, 1'b1);
    readout(0, "partial");
    check_stats("partial", 16'd2, 1'b1);
  endtask

  task automatic test_stall();
    start_run(16'd1);
    check_stats("stall_start", 16'd0, 1'b0);
    drive_frame(512, 2, '0, 1, -1, '0);
    readout(1, "stall");
    check_stats("stall", 16'd1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_run(16'd2);
    for (int i = 0; i < 200; i++) begin
      data_valid = 1'b1;
      Power_Spec = 50'(i * 3);
      @(negedge clk);
    end
    rst = 1'b1;
    data_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    @(negedge clk);
    start_run(16'd0);
    drive_frame(512, 2, '0, 1, -1, '0);
    readout(0, "after_reset");
    check_stats("after_reset", 16'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_midframe();
    test_partial();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
